// File: rtl/snow64_instr_cache.sv
// snow64_instr_cache: direct-mapped, read-only instruction cache feeding IF/ID.
// One fetch per cycle on a hit (1-cycle latency); a miss refills a whole line
// from the memory arbiter and returns the requested word from the fresh line.
//
// Handshake: in_req/in_addr are sampled on a rising edge only while the cache
// is idle (out_busy=0); each accepted request produces exactly one out_valid
// pulse. out_mem_req stays high with a stable out_mem_addr until a single-cycle
// in_mem_valid arrives; in_mem_valid at any other time is ignored.
module snow64_instr_cache #(
  parameter int WIDTH_ADDR  = 64,
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_LINE  = 256,
  parameter int NUM_LINES   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_req,
  input  logic [WIDTH_ADDR-1:0]  in_addr,
  input  logic                   in_flush,
  output logic                   out_valid,
  output logic [WIDTH_INSTR-1:0] out_instr,
  output logic                   out_busy,
  output logic                   out_mem_req,
  output logic [WIDTH_ADDR-1:0]  out_mem_addr,
  input  logic                   in_mem_valid,
  input  logic [WIDTH_LINE-1:0]  in_mem_data,
  output logic [1:0]             dbg_state_o
);

  localparam int WB_W   = $clog2(WIDTH_INSTR / 8);          // byte-in-word bits
  localparam int WORD_W = $clog2(WIDTH_LINE / WIDTH_INSTR); // word-in-line bits
  localparam int OFF_W  = WB_W + WORD_W;                    // byte-in-line bits
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WIDTH_ADDR - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMiss = 2'd1,
    StFill = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [WIDTH_LINE-1:0]   line_q [NUM_LINES];
  logic [WIDTH_ADDR-1:0]   addr_q;
  logic                    flush_seen_q;
  logic                    out_valid_q;
  logic [WIDTH_INSTR-1:0]  out_instr_q;
  logic                    mem_req_q;
  logic [WIDTH_ADDR-1:0]   mem_addr_q;

  logic [IDX_W-1:0]  req_idx, miss_idx;
  logic [TAG_W-1:0]  req_tag, miss_tag;
  logic [WORD_W-1:0] req_word, miss_word;
  logic              hit;
  logic              lookup_hit, start_miss, fill_write, fill_done;
  logic              unused_addr_bits;

  function automatic logic [WIDTH_INSTR-1:0] sel_word(
    input logic [WIDTH_LINE-1:0] line,
    input logic [WORD_W-1:0]     w
  );
    return line[w*WIDTH_INSTR +: WIDTH_INSTR];
  endfunction

  assign req_idx   = in_addr[OFF_W +: IDX_W];
  assign req_tag   = in_addr[WIDTH_ADDR-1 -: TAG_W];
  assign req_word  = in_addr[WB_W +: WORD_W];
  assign miss_idx  = addr_q[OFF_W +: IDX_W];
  assign miss_tag  = addr_q[WIDTH_ADDR-1 -: TAG_W];
  assign miss_word = addr_q[WB_W +: WORD_W];

  // A flush on the lookup edge wins over the stored valid bit.
  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !in_flush;

  // Byte-within-word bits never affect which word is fetched.
  assign unused_addr_bits = ^{in_addr[WB_W-1:0], addr_q[WB_W-1:0]};

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_busy     = (state_q != StIdle);
  assign out_mem_req  = mem_req_q;
  assign out_mem_addr = mem_addr_q;
  assign dbg_state_o  = state_q;

  // Next-state and per-edge control strobes.
  always_comb begin
    state_d    = state_q;
    lookup_hit = 1'b0;
    start_miss = 1'b0;
    fill_write = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_req) begin
          if (hit) begin
            lookup_hit = 1'b1;
          end else begin
            start_miss = 1'b1;
            state_d    = StMiss;
          end
        end
      end
      StMiss: begin
        if (in_mem_valid) begin
          fill_write = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        fill_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Valid bits: flush clears everything; a refill tainted by a flush stays invalid.
  always_comb begin
    valid_d = in_flush ? '0 : valid_q;
    if (fill_write) begin
      valid_d[miss_idx] = !(flush_seen_q || in_flush);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      addr_q       <= '0;
      flush_seen_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      out_valid_q <= lookup_hit || fill_done;
      if (lookup_hit) begin
        out_instr_q <= sel_word(line_q[req_idx], req_word);
      end else if (fill_done) begin
        out_instr_q <= sel_word(line_q[miss_idx], miss_word);
      end
      if (start_miss) begin
        addr_q       <= in_addr;
        mem_req_q    <= 1'b1;
        mem_addr_q   <= {in_addr[WIDTH_ADDR-1:OFF_W], {OFF_W{1'b0}}};
        flush_seen_q <= 1'b0;
      end else begin
        if (fill_write) begin
          mem_req_q <= 1'b0;
        end
        if (state_q == StMiss && in_flush) begin
          flush_seen_q <= 1'b1;
        end
      end
    end
  end

  // Tag and line storage; only meaningful when the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      line_q[miss_idx] <= in_mem_data;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: doc/snow64_instr_cache.md
Name: snow64_instr_cache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the IF/ID stage.
- Accepts one fetch request per cycle from IF/ID and returns one instruction word with a valid pulse.
- On a miss, refills one whole line from the memory arbiter.
- The flush input invalidates all lines so that code written by stores becomes visible to fetch.

Parameters:
WIDTH_ADDR, 64, CPU address width
WIDTH_INSTR, 32, instruction width; word offset = addr[1:0], ignored
WIDTH_LINE, 256, line width; byte offset = addr[4:0], word select = addr[4:2]
NUM_LINES, 16, line count, power of two; index = addr[8:5], tag = addr[63:9]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_req  in  1  fetch request from IF/ID
in_addr  in  WIDTH_ADDR  fetch byte address, sampled with in_req
in_flush  in  1  invalidate all lines
out_valid  out  1  instruction valid, one-cycle pulse per accepted request
out_instr  out  WIDTH_INSTR  fetched instruction, meaningful only while out_valid=1
out_busy  out  1  high in StMiss/StFill; requests are not accepted
out_mem_req  out  1  line refill request
out_mem_addr  out  WIDTH_ADDR  line-aligned refill address (low 5 bits zero)
in_mem_valid  in  1  refill data valid, one cycle
in_mem_data  in  WIDTH_LINE  refill line; word k = bits [32k+31:32k]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all valid bits = 0, state = StIdle, and every output = 0 (out_valid, out_instr, out_busy, out_mem_req, out_mem_addr).
- Storage: NUM_LINES x (valid, tag, line) registers. Words within a line are little-endian: word 0 is at the lowest address.
- StIdle behaviour:
  - in_req=1 and hit (valid[idx] && tag[idx]==addr tag): the next cycle drives out_valid=1 and out_instr = the selected word. Hit latency is 1 cycle, and back-to-back hits give one result per cycle.
  - in_req=1 and miss: latch the address, set out_mem_addr = {addr[63:5],5'b0} and out_mem_req=1, then go to StMiss. out_valid=0 and out_busy=1 from the next cycle.
  - in_req=0: out_valid=0.
- StMiss behaviour:
  - Hold out_mem_req=1 and keep out_mem_addr stable until in_mem_valid=1.
  - On in_mem_valid: write the line, set valid and tag, drop out_mem_req, and go to StFill.
  - in_req is ignored while in StMiss.
- StFill behaviour:
  - Drive out_valid=1 with the requested word from the just-filled line, deassert out_busy, then return to StIdle.
  - Miss latency = memory latency + 2 cycles after the request edge.
  - in_req is ignored in StFill; IF/ID re-presents it.
- in_mem_valid outside StMiss is ignored: no write, no state change.
- Flush rules:
  - in_flush clears all valid bits on that edge, with priority over a simultaneous hit lookup. A request on the same edge is treated as a miss.
  - A flush during StMiss does not abort the refill. If the flush coincides with, or precedes, in_mem_valid within the same miss, the line is written but its valid bit stays 0; the requested word is still returned in StFill.
- Reset mid-miss: all state returns to reset values immediately, out_mem_req drops asynchronously, and any later in_mem_valid is ignored.
- Tag comparison covers the full upper address bits; there is no partial tag.

Test Plan:
- Reset, then in_req with addr 0x1000 -> miss: out_mem_req=1 with out_mem_addr=0x1000. Respond 3 cycles later with data word k = 0xA000_0000+k -> out_valid pulses one cycle with 0xA000_0000, out_busy is high throughout the miss.
- After that fill, requests at 0x1004, 0x1008, 0x101C on consecutive cycles -> out_valid=1 for 3 consecutive cycles with 0xA000_0001, 0xA000_0002, 0xA000_0007.
- Fill 0x1000, then request 0x1200 (same index 0, different tag) -> miss with out_mem_addr=0x1200. A subsequent request at 0x1000 also misses.
- Assert in_flush in the same cycle as a request to cached 0x1000 -> treated as a miss and out_mem_req=1. Separately, assert in_flush during StMiss -> the requested word is returned, but the next request to the same line misses again.
- Pulse in_mem_valid while in StIdle -> no out_valid and the cached line is unchanged. Assert rst_n=0 during StMiss -> out_mem_req=0 immediately, and a request after reset misses.
